// File: rtl/post_adder_acc.sv
// post_adder_acc: DSP post-adder/accumulator, p <= Z +/- (X + carry_in), with sticky signed overflow.
// Latency: 1 cycle from accepted operands (ce_i & in_valid_i) to p_o/carryout_o/out_valid_o.
// Backpressure: none; ce_i=0 freezes every register, in_valid_i=0 bubbles hold p/carryout.
// Optional feature: define POST_ADD_SAT_EN to clamp p to the signed range on overflow.
module post_adder_acc #(
    parameter int M_WIDTH = 36,
    parameter int P_WIDTH = 48
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ce_i,
    input  logic               in_valid_i,
    input  logic [4:0]         opmode_i,
    input  logic               carry_in_i,
    input  logic [M_WIDTH-1:0] m_i,
    input  logic [P_WIDTH-1:0] dab_i,
    input  logic [P_WIDTH-1:0] c_i,
    input  logic [P_WIDTH-1:0] pcin_i,
    input  logic               clr_ovf_i,
    output logic [P_WIDTH-1:0] p_o,
    output logic [P_WIDTH-1:0] pcout_o,
    output logic               carryout_o,
    output logic               out_valid_o,
    output logic               ovf_o
);

    // Two guard bits hold the exact signed result of Z +/- (X + cin).
    localparam int EW = P_WIDTH + 2;

    logic [P_WIDTH-1:0]   p_q, p_d;
    logic                 carry_q, carry_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ovf_q, ovf_d;

    logic [P_WIDTH-1:0]   x_sel;
    logic [P_WIDTH-1:0]   z_sel;
    logic [P_WIDTH:0]     r_sum;
    logic signed [EW-1:0] x_ext, z_ext, cin_ext, exact;
    logic                 ovfl;
    logic [P_WIDTH-1:0]   res;

    // Operand selection; p is taken from the register so feedback is never combinational.
    always_comb begin
        x_sel = '0;
        z_sel = '0;
        unique case (opmode_i[1:0])
            2'd0: x_sel = '0;
            2'd1: x_sel = {{(P_WIDTH-M_WIDTH){m_i[M_WIDTH-1]}}, m_i};
            2'd2: x_sel = p_q;
            2'd3: x_sel = dab_i;
            default: x_sel = '0;
        endcase
        unique case (opmode_i[3:2])
            2'd0: z_sel = '0;
            2'd1: z_sel = pcin_i;
            2'd2: z_sel = p_q;
            2'd3: z_sel = c_i;
            default: z_sel = '0;
        endcase
    end

    // Unsigned post-add for result/carry, plus a widened signed copy for overflow detection.
    always_comb begin
        x_ext   = {{2{x_sel[P_WIDTH-1]}}, x_sel};
        z_ext   = {{2{z_sel[P_WIDTH-1]}}, z_sel};
        cin_ext = {{(EW-1){1'b0}}, carry_in_i};
        if (opmode_i[4]) begin
            r_sum = {1'b0, z_sel} - {1'b0, x_sel} - {{P_WIDTH{1'b0}}, carry_in_i};
            exact = z_ext - x_ext - cin_ext;
        end else begin
            r_sum = {1'b0, z_sel} + {1'b0, x_sel} + {{P_WIDTH{1'b0}}, carry_in_i};
            exact = z_ext + x_ext + cin_ext;
        end
        // Overflow whenever the exact value differs from its P_WIDTH-bit sign-extended truncation.
        ovfl = (exact != {{2{exact[P_WIDTH-1]}}, exact[P_WIDTH-1:0]});
    end

    // Result selection: wrap by default, clamp to the signed limits when saturation is built in.
    always_comb begin
`ifdef POST_ADD_SAT_EN
        if (ovfl) begin
            res = exact[EW-1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
        end else begin
            res = r_sum[P_WIDTH-1:0];
        end
`else
        res = r_sum[P_WIDTH-1:0];
`endif
    end

    // Next-state: bubbles hold the accumulator, an overflow set wins over a same-cycle clear.
    always_comb begin
        p_d         = p_q;
        carry_d     = carry_q;
        out_valid_d = in_valid_i;
        ovf_d       = ovf_q;
        if (in_valid_i) begin
            p_d     = res;
            carry_d = r_sum[P_WIDTH];
        end
        if (in_valid_i && ovfl) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // State registers: reset dominates, ce gates every update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q         <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (ce_i) begin
            p_q         <= p_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign p_o         = p_q;
    assign pcout_o     = p_q;
    assign carryout_o  = carry_q;
    assign out_valid_o = out_valid_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_post_adder_acc.sv
// tb_post_adder_acc: scoreboard bench for post_adder_acc with an arithmetic reference model.
// Directed scenarios (reset, MAC, subtract, overflow, bubbles, ce freeze, mid-run reset) then random traffic.
// Build with POST_ADD_SAT_EN defined to exercise the saturating variant.
module tb_post_adder_acc;

    localparam longint TWO48 = longint'(1) << 48;
    localparam longint TWO36 = longint'(1) << 36;
    localparam longint MASK  = TWO48 - 1;
    localparam longint MAXP  = (longint'(1) << 47) - 1;
    localparam longint MINP  = -(longint'(1) << 47);

    logic        clk = 1'b0;
    logic        rst, ce, in_valid, carry_in, clr_ovf;
    logic [4:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic [47:0] p, pcout;
    logic        carryout, out_valid, ovf;

    post_adder_acc dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid),
        .opmode_i(opmode), .carry_in_i(carry_in), .m_i(m), .dab_i(dab),
        .c_i(c), .pcin_i(pcin), .clr_ovf_i(clr_ovf),
        .p_o(p), .pcout_o(pcout), .carryout_o(carryout),
        .out_valid_o(out_valid), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] p;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t   sb_q[$];
    int     tests = 0;
    int     fails = 0;

    // Reference state: what the DUT outputs should be after the most recent edge.
    longint mp = 0;
    bit     mco = 0;
    bit     movf = 0;

    bit last_ce = 0, last_rst = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic longint sx48(input logic [47:0] v);
        longint t = longint'({16'd0, v});
        if (v[47]) t = t - TWO48;
        return t;
    endfunction

    function automatic longint sx36(input logic [35:0] v);
        longint t = longint'({28'd0, v});
        if (v[35]) t = t - TWO36;
        return t;
    endfunction

    // One clock: apply inputs at negedge, advance the model, push the expected result for new outputs.
    task automatic cyc(input bit r, input bit e, input bit v, input logic [4:0] op, input bit ci,
                       input logic [35:0] mm, input logic [47:0] d, input logic [47:0] cc,
                       input logic [47:0] pc, input bit clr);
        longint xs, zs, xu, zu, ex, raw, pn;
        bit co, of;
        exp_t it;
        @(negedge clk);
        rst = r; ce = e; in_valid = v; opmode = op; carry_in = ci;
        m = mm; dab = d; c = cc; pcin = pc; clr_ovf = clr;
        case (op[1:0])
            2'd0: xs = 0;
            2'd1: xs = sx36(mm);
            2'd2: xs = sx48(mp[47:0]);
            default: xs = sx48(d);
        endcase
        case (op[3:2])
            2'd0: zs = 0;
            2'd1: zs = sx48(pc);
            2'd2: zs = sx48(mp[47:0]);
            default: zs = sx48(cc);
        endcase
        xu = xs & MASK;
        zu = zs & MASK;
        if (op[4]) begin
            ex  = zs - (xs + longint'(ci));
            raw = zu - xu - longint'(ci);
            co  = (raw < 0);
        end else begin
            ex  = zs + xs + longint'(ci);
            raw = zu + xu + longint'(ci);
            co  = (raw >= TWO48);
        end
        pn = raw & MASK;
        of = (ex > MAXP) || (ex < MINP);
`ifdef POST_ADD_SAT_EN
        if (of) pn = (ex > 0) ? MAXP : (MINP & MASK);
`endif
        if (r) begin
            mp = 0; mco = 0; movf = 0;
        end else if (e) begin
            if (v) begin
                mp = pn; mco = co;
            end
            if (v && of) movf = 1;
            else if (clr) movf = 0;
            if (v) begin
                it.p = mp[47:0]; it.co = mco; it.ovf = movf;
                sb_q.push_back(it);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Capture the control state seen at each edge so the monitor knows a fresh result was produced.
    always @(posedge clk) begin
        last_ce  = ce;
        last_rst = rst;
    end

    // Monitor: each freshly produced valid result is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && last_ce && !last_rst) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_p", {16'd0, p}, {16'd0, e.p});
                chk("sb_pcout", {16'd0, pcout}, {16'd0, e.p});
                chk("sb_carryout", {63'd0, carryout}, {63'd0, e.co});
                chk("sb_ovf", {63'd0, ovf}, {63'd0, e.ovf});
            end
        end
    end

    function automatic logic [47:0] rnd48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: return 48'h0;
            1: return 48'h7FFF_FFFF_FFFF;
            2: return 48'h8000_0000_0000;
            3: return 48'hFFFF_FFFF_FFFF;
            4: return 48'($urandom_range(0, 100));
            default: return t[47:0];
        endcase
    endfunction

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return 36'h7_FFFF_FFFF;
            1: return 36'h8_0000_0000;
            2: return 36'($urandom_range(0, 50));
            default: return t[35:0];
        endcase
    endfunction

    localparam logic [4:0] OP_MAC = 5'b01001;
    localparam logic [4:0] OP_SUB = 5'b11101;
    localparam logic [4:0] OP_ADC = 5'b01101;

    initial begin
        logic [47:0] sat_exp;
        rst = 1; ce = 0; in_valid = 1; opmode = '0; carry_in = 0;
        m = '0; dab = '0; c = '0; pcin = '0; clr_ovf = 0;

        // Reset with ce=0 and in_valid=1 still clears everything.
        cyc(1, 0, 1, OP_MAC, 0, 36'd0, 48'd0, 48'd0, 48'd0, 0);
        chk("rst_p", {16'd0, p}, 64'd0);
        chk("rst_carryout", {63'd0, carryout}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);

        // Multiply-accumulate 5 per cycle.
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
            chk("mac_p", {16'd0, p}, 64'(5 * i));
            chk("mac_out_valid", {63'd0, out_valid}, 64'd1);
        end

        // Two bubbles hold p and drop out_valid, then accumulation resumes.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
            chk("bubble_p", {16'd0, p}, 64'd20);
            chk("bubble_out_valid", {63'd0, out_valid}, 64'd0);
        end
        cyc(0, 1, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        chk("resume_p", {16'd0, p}, 64'd25);
        cyc(0, 1, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        chk("resume_p2", {16'd0, p}, 64'd30);

        // ce=0 freezes every output even with valid input.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
            chk("freeze_p", {16'd0, p}, 64'd30);
            chk("freeze_out_valid", {63'd0, out_valid}, 64'd1);
        end

        // Reset in the middle of an accumulation.
        cyc(1, 1, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        chk("pre_rst_p", {16'd0, p}, 64'd15);
        cyc(1, 1, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        chk("midrst_p", {16'd0, p}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        cyc(0, 1, 1, OP_MAC, 0, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        chk("after_rst_p", {16'd0, p}, 64'd5);

        // Subtraction with carry-in as borrow, and a borrow-out case.
        cyc(0, 1, 1, OP_SUB, 1, 36'd30, 48'd0, 48'd100, 48'd0, 0);
        chk("subA_p", {16'd0, p}, 64'd69);
        chk("subA_carryout", {63'd0, carryout}, 64'd0);
        cyc(0, 1, 1, OP_SUB, 0, 36'd20, 48'd0, 48'd10, 48'd0, 0);
        chk("subB_p", {16'd0, p}, 64'h0000_FFFF_FFFF_FFF6);
        chk("subB_carryout", {63'd0, carryout}, 64'd1);

        // Signed overflow on max positive + 1, then sticky behaviour of ovf.
`ifdef POST_ADD_SAT_EN
        sat_exp = 48'h7FFF_FFFF_FFFF;
`else
        sat_exp = 48'h8000_0000_0000;
`endif
        cyc(0, 1, 1, OP_ADC, 0, 36'd1, 48'd0, 48'h7FFF_FFFF_FFFF, 48'd0, 0);
        chk("ovf_set", {63'd0, ovf}, 64'd1);
        chk("ovf_p", {16'd0, p}, {16'd0, sat_exp});
        chk("ovf_carryout", {63'd0, carryout}, 64'd0);
        cyc(0, 1, 1, OP_ADC, 0, 36'd1, 48'd0, 48'd1, 48'd0, 0);
        chk("ovf_sticky_p", {16'd0, p}, 64'd2);
        chk("ovf_sticky", {63'd0, ovf}, 64'd1);
        cyc(0, 0, 0, OP_ADC, 0, 36'd1, 48'd0, 48'd1, 48'd0, 1);
        chk("ovf_clr_no_ce", {63'd0, ovf}, 64'd1);
        cyc(0, 1, 0, OP_ADC, 0, 36'd1, 48'd0, 48'd1, 48'd0, 1);
        chk("ovf_cleared", {63'd0, ovf}, 64'd0);
        cyc(0, 1, 1, OP_ADC, 0, 36'h8_0000_0000, 48'd0, 48'h8000_0000_0000, 48'd0, 1);
        chk("ovf_set_beats_clr", {63'd0, ovf}, 64'd1);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), rnd36(), rnd48(), rnd48(), rnd48(),
                ($urandom_range(0, 9) == 0));
        end

        // Idle so the last result drains through the monitor.
        cyc(0, 0, 0, OP_MAC, 0, 36'd0, 48'd0, 48'd0, 48'd0, 0);
        cyc(0, 0, 0, OP_MAC, 0, 36'd0, 48'd0, 48'd0, 48'd0, 0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
